and_result_buffer: RTL and testbench

Two-entry elastic buffer that sits directly downstream of the 4-bit `and1` stage. It captures each result pair: `c`, the AND of the two operands, and `d`, the stage's constant flag word. It then presents the pairs in order to the next consumer over a valid/ready handshake. It also keeps a wrapping count of accepted pairs and a saturating count of pairs whose AND result is non-zero. This lets a property checker bound how many results have passed through.

---
 rtl/and_result_buffer.sv | 99 +++++++++
 tb/tb_and_result_buffer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/and_result_buffer.sv
// Two-entry elastic buffer for and1 stage results with accepted/non-zero counters.
// Optional `AND_RESULT_PARITY_EN adds a stored even-parity bit per entry (out_par).
module and_result_buffer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_c,
  input  logic [3:0]       in_d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_c,
  output logic [3:0]       out_d,
  output logic [CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0] nz_cnt
`ifdef AND_RESULT_PARITY_EN
  ,
  output logic             out_par
`endif
);

`ifdef AND_RESULT_PARITY_EN
  localparam int unsigned EW = 9;
`else
  localparam int unsigned EW = 8;
`endif

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic            wp, rp;
  logic [EW-1:0]   mem [2];
  logic [EW-1:0]   wdata;
  logic            push, pop;

`ifdef AND_RESULT_PARITY_EN
  assign wdata = {^{in_c, in_d}, in_c, in_d};
`else
  assign wdata = {in_c, in_d};
`endif

  // Handshake flags come only from registered state, so no out_ready -> in_ready path.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_c     = mem[rp][7:4];
  assign out_d     = mem[rp][3:0];
`ifdef AND_RESULT_PARITY_EN
  assign out_par   = mem[rp][8];
`endif

  always_comb begin
    state_nx = state;
    push     = in_valid && in_ready;
    pop      = out_valid && out_ready;
    case (state)
      EMPTY: if (push) state_nx = ONE;
      ONE: begin
        if (push && !pop)      state_nx = FULL;
        else if (pop && !push) state_nx = EMPTY;
      end
      FULL:    if (pop) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp      <= 1'b0;
      rp      <= 1'b0;
      mem[0]  <= '0;
      mem[1]  <= '0;
      acc_cnt <= '0;
      nz_cnt  <= '0;
    end else begin
      if (push) begin
        mem[wp] <= wdata;
        wp      <= ~wp;
        acc_cnt <= acc_cnt + CNT_W'(1);
        if ((in_c != 4'd0) && (nz_cnt != '1)) nz_cnt <= nz_cnt + CNT_W'(1);
      end
      if (pop) rp <= ~rp;
    end
  end

endmodule

// File: tb/tb_and_result_buffer.sv
// Directed self-checking bench for and_result_buffer (immediate assertions per check).
module tb_and_result_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_c;
  logic [3:0] in_d;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_c;
  logic [3:0] out_d;
  logic [7:0] acc_cnt;
  logic [7:0] nz_cnt;
`ifdef AND_RESULT_PARITY_EN
  logic       out_par;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  and_result_buffer #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_c      (in_c),
    .in_d      (in_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_d     (out_d),
    .acc_cnt   (acc_cnt),
    .nz_cnt    (nz_cnt)
`ifdef AND_RESULT_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_c = 4'd0; in_d = 4'd0;
    #1;
    chk("in_ready_in_rst", 16'(in_ready), 16'd1);
    in_valid = 1'b1; in_c = 4'd9; in_d = 4'd9;
    tick();
    chk("no_push_in_rst_acc", 16'(acc_cnt), 16'd0);
    chk("no_push_in_rst_vld", 16'(out_valid), 16'd0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_in_ready",  16'(in_ready),  16'd1);
    chk("rst_acc",       16'(acc_cnt),   16'd0);
    chk("rst_nz",        16'(nz_cnt),    16'd0);
    chk("rst_out_c",     16'(out_c),     16'd0);
    chk("rst_out_d",     16'(out_d),     16'd0);
`ifdef AND_RESULT_PARITY_EN
    chk("rst_out_par",   16'(out_par),   16'd0);
`endif

    // single pass
    in_valid = 1'b1; in_c = 4'b0101; in_d = 4'b0001; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("single_valid", 16'(out_valid), 16'd1);
    chk("single_c",     16'(out_c),     16'd5);
    chk("single_d",     16'(out_d),     16'd1);
    chk("single_acc",   16'(acc_cnt),   16'd1);
    chk("single_nz",    16'(nz_cnt),    16'd1);
    tick();
    chk("single_drain", 16'(out_valid), 16'd0);

    // fill and stall
    do_reset();
    in_valid = 1'b1; in_c = 4'd3; in_d = 4'd2;
    tick();
    in_c = 4'd0; in_d = 4'd4;
    tick();
    in_c = 4'd7; in_d = 4'd7;
    chk("full_in_ready", 16'(in_ready), 16'd0);
    tick();
    chk("full_ignored_acc", 16'(acc_cnt), 16'd2);
    chk("full_ignored_nz",  16'(nz_cnt),  16'd1);
    chk("full_stable_c",    16'(out_c),   16'd3);
    chk("full_stable_d",    16'(out_d),   16'd2);
    in_c = 4'd9; in_d = 4'd0; out_ready = 1'b1;
    tick();
    chk("full_pop_only_c",   16'(out_c),     16'd0);
    chk("full_pop_only_d",   16'(out_d),     16'd4);
    chk("full_pop_only_vld", 16'(out_valid), 16'd1);
    chk("full_pop_only_acc", 16'(acc_cnt),   16'd2);
    chk("full_pop_rdy",      16'(in_ready),  16'd1);
    in_valid = 1'b0;
    tick();
    chk("fill_drain", 16'(out_valid), 16'd0);

    // streaming
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1; in_c = 4'(i); in_d = 4'hA;
      tick();
      chk("stream_valid", 16'(out_valid), 16'd1);
      chk("stream_c",     16'(out_c),     16'(i));
    end
    in_valid = 1'b0;
    chk("stream_acc", 16'(acc_cnt), 16'd10);
    chk("stream_nz",  16'(nz_cnt),  16'd10);
    tick();
    chk("stream_drain", 16'(out_valid), 16'd0);

    // wrap / saturate
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_c = 4'hF; in_d = 4'd0;
    repeat (256) tick();
    chk("wrap_acc", 16'(acc_cnt), 16'd0);
    chk("sat_nz",   16'(nz_cnt),  16'd255);
    tick();
    chk("wrap_acc_plus1", 16'(acc_cnt), 16'd1);
    chk("sat_nz_hold",    16'(nz_cnt),  16'd255);
    in_valid = 1'b0;

    // asynchronous reset while full
    do_reset();
    in_valid = 1'b1; in_c = 4'd1; in_d = 4'd0;
    tick();
    in_c = 4'd2; in_d = 4'd3;
    tick();
    in_valid = 1'b0;
    chk("pre_arst_valid", 16'(out_valid), 16'd1);
    chk("pre_arst_acc",   16'(acc_cnt),   16'd2);
    chk("pre_arst_ready", 16'(in_ready),  16'd0);
`ifdef AND_RESULT_PARITY_EN
    chk("pre_arst_par",   16'(out_par),   16'd1);
`endif
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 16'(out_valid), 16'd0);
    chk("arst_acc",   16'(acc_cnt),   16'd0);
    chk("arst_nz",    16'(nz_cnt),    16'd0);
    chk("arst_ready", 16'(in_ready),  16'd1);
    chk("arst_c",     16'(out_c),     16'd0);
`ifdef AND_RESULT_PARITY_EN
    chk("arst_par",   16'(out_par),   16'd0);
`endif
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
